// File: rtl/fifo_port_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_port_arbiter
//
// Shares one single-port gray-pointer FIFO (shared tri-state data bus) between
// NUM_REQ producers and a single consumer. Producers are served round-robin.
// Every FIFO access is a single-cycle WRITE or READ entered from IDLE and
// returning to IDLE, so the FIFO flags are always settled when a decision is
// made. This block is the only driver of the FIFO enables. It drives the data
// bus only while it is writing.
//
// Ports:
//   clk            clock, all state on the rising edge
//   rst            asynchronous, active-low reset
//   req            per-producer write request (level, held until gnt)
//   req_data       producer words, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt            one-hot 1-cycle pulse: channel word written this cycle
//   gnt_idx        index of the last granted channel
//   rd_req         consumer wants a word (level)
//   rd_valid       1-cycle pulse, rd_data holds a popped word
//   rd_data        registered popped word
//   fifo_en_write  FIFO write enable
//   fifo_en_read   FIFO read enable
//   fifo_databus   FIFO shared bi-directional data bus
//   fifo_empty     FIFO empty flag
//   fifo_full      FIFO full flag (7 usable words)
// -----------------------------------------------------------------------------
module fifo_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 1,
    parameter int REQ_WIDTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [REQ_WIDTH-1:0]          gnt_idx,
    input  logic                          rd_req,
    output logic                          rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          fifo_en_write,
    output logic                          fifo_en_read,
    inout  wire  [DATA_WIDTH-1:0]         fifo_databus,
    input  logic                          fifo_empty,
    input  logic                          fifo_full
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [REQ_WIDTH-1:0]    ptr_reg;        // round-robin start channel
    logic                    last_wr_reg;    // 1: last op was a write
    logic [DATA_WIDTH-1:0]   wr_data_reg;    // word being put on the bus
    logic [NUM_REQ-1:0]      gnt_reg;
    logic [REQ_WIDTH-1:0]    gnt_idx_reg;
    logic                    rd_valid_reg;
    logic [DATA_WIDTH-1:0]   rd_data_reg;
    logic                    en_write_reg;
    logic                    en_read_reg;

    // -------------------------------------------------------------------------
    // Per-channel word unpacking and round-robin mask
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]   ch_data [NUM_REQ];
    logic [NUM_REQ-1:0]      upper_mask;     // channels at or above the pointer

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_chan
            assign ch_data[gi]    = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign upper_mask[gi] = (REQ_WIDTH'(gi) >= ptr_reg);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Channel selection: lowest requesting channel at or above the pointer;
    // if none, wrap around and take the lowest requesting channel overall.
    // -------------------------------------------------------------------------
    logic [NUM_REQ-1:0]      hi_req;
    logic [NUM_REQ-1:0]      pick_src;
    logic [REQ_WIDTH-1:0]    sel_idx;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [NUM_REQ-1:0]      sel_onehot;
    logic [REQ_WIDTH-1:0]    ptr_next;

    always_comb begin
        hi_req   = req & upper_mask;
        pick_src = (|hi_req) ? hi_req : req;
        sel_idx  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pick_src[i]) begin
                sel_idx = REQ_WIDTH'(i);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == REQ_WIDTH'(i)) begin
                sel_data = ch_data[i];
            end
        end
    end

    assign sel_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
    assign ptr_next   = (sel_idx == REQ_WIDTH'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;

    // -------------------------------------------------------------------------
    // IDLE decision. rd_req is ignored while rd_valid is high so the consumer
    // has a cycle to drop it after receiving a word.
    // -------------------------------------------------------------------------
    logic wr_ok;
    logic rd_ok;
    logic do_write;
    logic do_read;

    assign wr_ok    = (|req) && !fifo_full;
    assign rd_ok    = rd_req && !fifo_empty && !rd_valid_reg;
    assign do_write = wr_ok && (!rd_ok || !last_wr_reg);
    assign do_read  = rd_ok && (!wr_ok || last_wr_reg);

    // -------------------------------------------------------------------------
    // FSM with registered outputs. Enables are set on entry to WRITE/READ so
    // they are high for exactly the one cycle spent in that state.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= '0;
            last_wr_reg  <= 1'b0;
            wr_data_reg  <= '0;
            gnt_reg      <= '0;
            gnt_idx_reg  <= '0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
            en_write_reg <= 1'b0;
            en_read_reg  <= 1'b0;
        end else begin
            gnt_reg      <= '0;
            rd_valid_reg <= 1'b0;
            en_write_reg <= 1'b0;
            en_read_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (do_write) begin
                        state_reg    <= ST_WRITE;
                        gnt_reg      <= sel_onehot;
                        gnt_idx_reg  <= sel_idx;
                        ptr_reg      <= ptr_next;
                        wr_data_reg  <= sel_data;
                        last_wr_reg  <= 1'b1;
                        en_write_reg <= 1'b1;
                    end else if (do_read) begin
                        state_reg    <= ST_READ;
                        last_wr_reg  <= 1'b0;
                        en_read_reg  <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    state_reg <= ST_IDLE;
                end
                ST_READ: begin
                    // FIFO drives the bus while en_read is high.
                    state_reg    <= ST_IDLE;
                    rd_data_reg  <= fifo_databus;
                    rd_valid_reg <= 1'b1;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus is driven only during WRITE; released otherwise (and in reset).
    assign fifo_databus  = en_write_reg ? wr_data_reg : {DATA_WIDTH{1'bz}};

    assign gnt           = gnt_reg;
    assign gnt_idx       = gnt_idx_reg;
    assign rd_valid      = rd_valid_reg;
    assign rd_data       = rd_data_reg;
    assign fifo_en_write = en_write_reg;
    assign fifo_en_read  = en_read_reg;

endmodule

// File: doc/fifo_port_arbiter.md
Name: fifo_port_arbiter

Overview:
- Controller that shares the single-port 8-entry gray-pointer FIFO (shared tri-state databus, write-priority enables) between NUM_REQ producers and one consumer.
- Round-robin arbitration picks which producer writes. Read and write are sequenced so they never overlap, and bus direction is owned here.
- Sits directly between producer/consumer logic and the FIFO instance. It is the only block allowed to drive the FIFO's enables.

Parameters:
- NUM_REQ, 4, number of producer channels (2..8).
- DATA_WIDTH, 1, FIFO word width; must match the FIFO instance.
- REQ_WIDTH, 2, width of the grant index; equals ceil(log2(NUM_REQ)), 1 minimum.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-producer write request, level; held until its gnt bit pulses.
- req_data  input  NUM_REQ*DATA_WIDTH  producer words, channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  output  NUM_REQ  one-hot, 1-cycle pulse: word of channel i is being written this cycle.
- gnt_idx  output  REQ_WIDTH  index of the last granted channel.
- rd_req  input  1  consumer wants a word, level.
- rd_valid  output  1  1-cycle pulse, rd_data holds a popped word.
- rd_data  output  DATA_WIDTH  registered popped word.
- fifo_en_write  output  1  FIFO write enable.
- fifo_en_read  output  1  FIFO read enable.
- fifo_databus  inout  DATA_WIDTH  FIFO shared bus.
- fifo_empty  input  1  FIFO empty flag.
- fifo_full  input  1  FIFO full flag; usable capacity is 7 words.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; gnt=0, gnt_idx=0, rd_valid=0, rd_data=0, fifo_en_write=0, fifo_en_read=0.
  - fifo_databus released to Z; round-robin pointer=0; last_op=READ.
- Reset mid-WRITE or mid-READ aborts immediately: enables drop, bus goes Z, no gnt or rd_valid pulse. The FIFO is reset by the same rst.
- FSM states: IDLE, WRITE, READ. Every operation is IDLE -> op -> IDLE, so the FIFO flags are always settled when sampled in IDLE.
- IDLE decision, evaluated every IDLE cycle:
  - wr_ok = |req && !fifo_full.
  - rd_ok = rd_req && !fifo_empty && !rd_valid. rd_req is ignored in the cycle rd_valid=1, which gives the consumer time to drop it.
  - Both ok: alternate; go WRITE if last_op==READ, else READ.
  - Only one ok: take that op.
  - Neither: stay IDLE.
- Entering WRITE:
  - Select channel g = first set req bit scanning from pointer upward, wrapping modulo NUM_REQ.
  - Latch req_data[g] into a write register; gnt_idx<=g; pointer<=(g+1) mod NUM_REQ; last_op<=WRITE.
- WRITE (exactly 1 cycle):
  - fifo_en_write=1; fifo_databus driven with the latched word; gnt[g]=1.
  - FIFO captures on the closing edge; next state IDLE.
  - The producer may drop or change req/req_data from the cycle after gnt.
- Entering READ: last_op<=READ.
- READ (exactly 1 cycle):
  - fifo_en_read=1; fifo_databus not driven by this block.
  - rd_data<=fifo_databus on the closing edge; rd_valid=1 in the following cycle (IDLE).
- Latency:
  - req seen in IDLE at cycle t -> gnt and write at t+1.
  - rd_req seen in IDLE at t -> READ at t+1 -> rd_valid at t+2.
- Throughput: one write every 2 cycles; one read every 3 cycles when rd_req is held.
- Bus rule: fifo_databus is driven only in WRITE. fifo_en_write and fifo_en_read are never both 1, so there is no contention and no reliance on the FIFO's write priority.
- Full: requests stay pending, no gnt, and the pointer does not move. Empty: rd_req stays pending, no read.
- A req bit dropped before its grant is simply skipped. A channel is never granted twice while any other channel is requesting.

Test Plan:
- Reset with DATA_WIDTH=4 -> all outputs 0, bus Z; after release with no requests, FIFO enables stay 0 for 20 cycles.
- req=4'b1111, data ch0..3 = 1,2,3,4 held until each gnt -> gnt order ch0,ch1,ch2,ch3 on cycles 1,3,5,7; FIFO holds 1,2,3,4.
- Fill with 7 writes on ch2 -> fifo_full=1; 8th request gets no gnt; one read returns the first word, rd_valid=1; the pending write then is granted.
- Empty FIFO, rd_req=1 -> no fifo_en_read; a single write of 4'hA on ch1 -> READ follows, rd_data=4'hA, rd_valid 1 cycle.
- Both req[0] and rd_req held with a non-empty FIFO -> ops alternate W,R,W,R; fifo_en_write & fifo_en_read is never 1.
- rst pulled low during WRITE -> enables 0 and bus Z in the same cycle; after release gnt_idx=0 and FSM in IDLE.
